// File: rtl/vxe_biu_regbank.sv
// vxe_biu_regbank: BIU-facing control/status register bank with
// masked interrupt events, alternating read/write arbitration.
module vxe_biu_regbank #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          NINTR      = 2,
    parameter logic [31:0] REG_ID     = 32'h5658_4531
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [ADDR_WIDTH-1:0] biu_waddr,
    input  logic                  biu_wenable,
    input  logic [31:0]           biu_wdata,
    input  logic [3:0]            biu_wben,
    output logic                  biu_waccept,
    output logic                  biu_werror,
    input  logic [ADDR_WIDTH-1:0] biu_raddr,
    input  logic                  biu_renable,
    output logic [31:0]           biu_rdata,
    output logic                  biu_raccept,
    output logic                  biu_rerror,
    output logic                  ctrl_enable,
    output logic                  ctrl_start,
    input  logic                  unit_busy,
    input  logic [NINTR-1:0]      intr_event,
    output logic                  intr
);

    typedef enum logic [1:0] {IDLE, WACC, RACC} state_t;

    localparam logic [5:0] OFF_ID   = 6'd0;
    localparam logic [5:0] OFF_CTRL = 6'd1;
    localparam logic [5:0] OFF_STAT = 6'd2;
    localparam logic [5:0] OFF_MASK = 6'd3;
    localparam logic [5:0] OFF_RAW  = 6'd4;
    localparam logic [5:0] OFF_ACT  = 6'd5;

    state_t           state, state_nx;
    logic             last_wr, last_wr_nx;
    logic [7:0]       addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wben_q;
    logic [NINTR-1:0] mask, mask_nx;
    logic [NINTR-1:0] raw, clr;
    logic [5:0]       off;
    logic             misal, bad_off, ro_reg;
    logic             werr_c, rerr_c, do_wr;
    logic [31:0]      rv;
    logic             unused_sink;

    // Only addr[7:0] matters; the rest of the bus is deliberately ignored.
    assign unused_sink = ^{biu_waddr, biu_raddr, biu_wdata};

    always_comb begin
        state_nx   = state;
        last_wr_nx = last_wr;
        case (state)
            IDLE: begin
                if (biu_wenable && (!biu_renable || !last_wr)) begin
                    state_nx   = WACC;
                    last_wr_nx = 1'b1;
                end else if (biu_renable) begin
                    state_nx   = RACC;
                    last_wr_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= IDLE;
            last_wr <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wben_q  <= '0;
        end else begin
            state   <= state_nx;
            last_wr <= last_wr_nx;
            if (state == IDLE && state_nx == WACC) begin
                addr_q  <= biu_waddr[7:0];
                wdata_q <= biu_wdata;
                wben_q  <= biu_wben;
            end else if (state == IDLE && state_nx == RACC) begin
                addr_q  <= biu_raddr[7:0];
            end
        end
    end

    assign off     = addr_q[7:2];
    assign misal   = |addr_q[1:0];
    assign bad_off = off > OFF_ACT;
    assign ro_reg  = (off == OFF_ID) || (off == OFF_STAT) || (off == OFF_ACT);
    assign werr_c  = misal || bad_off || ro_reg;
    assign rerr_c  = misal || bad_off;
    assign do_wr   = (state == WACC) && !werr_c;

    always_comb begin
        mask_nx = mask;
        clr     = '0;
        for (int i = 0; i < NINTR; i++) begin
            if (do_wr && off == OFF_MASK && wben_q[i/8])
                mask_nx[i] = wdata_q[i];
            if (do_wr && off == OFF_RAW && wben_q[i/8])
                clr[i] = wdata_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            ctrl_enable <= 1'b0;
            ctrl_start  <= 1'b0;
            mask        <= '0;
            raw         <= '0;
            intr        <= 1'b0;
        end else begin
            ctrl_start <= do_wr && off == OFF_CTRL && wben_q[0] && wdata_q[1];
            if (do_wr && off == OFF_CTRL && wben_q[0])
                ctrl_enable <= wdata_q[0];
            mask <= mask_nx;
            // A new event wins over a same-cycle clear.
            raw  <= (raw & ~clr) | intr_event;
            intr <= |(raw & mask);
        end
    end

    always_comb begin
        rv = '0;
        case (off)
            OFF_ID:   rv = REG_ID;
            OFF_CTRL: rv[0] = ctrl_enable;
            OFF_STAT: rv[0] = unit_busy;
            OFF_MASK: rv[NINTR-1:0] = mask;
            OFF_RAW:  rv[NINTR-1:0] = raw;
            OFF_ACT:  rv[NINTR-1:0] = raw & mask;
            default:  rv = '0;
        endcase
    end

    // Gating with nrst suppresses the handshake of an aborted transfer.
    assign biu_waccept = (state == WACC) && nrst;
    assign biu_werror  = (state == WACC) && nrst && werr_c;
    assign biu_raccept = (state == RACC) && nrst;
    assign biu_rerror  = (state == RACC) && nrst && rerr_c;
    assign biu_rdata   = ((state == RACC) && nrst && !rerr_c) ? rv : 32'h0;

endmodule
